cva6_refill_arbiter: RTL and testbench

Arbitrates instruction-cache and data-cache line-refill read requests onto one shared AXI read-address/read-data channel pair. It sits between the icache/HPDcache miss handlers and the AXI read port. Each requester has its own outstanding-transaction limit. Arbitration is round-robin. Read data is returned to the issuing cache by AXI ID.

---
 rtl/cva6_refill_arbiter.sv | 141 ++++++++++++++
 tb/tb_cva6_refill_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_refill_arbiter.sv
// cva6_refill_arbiter
//   Shares one AXI read-address / read-data channel pair between the icache
//   (requester 0) and the dcache (requester 1) refill paths. The arbiter
//   grants round-robin and caps the number of in-flight bursts per requester.
//   Read data is routed back to a requester by bit 0 of the AXI ID.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   per-requester refill request handshake
//   req_addr_i, req_len_i     per-requester burst start address and AXI len
//   ar_*                      AXI read-address channel (registered fields)
//   r_*                       AXI read-data channel (combinational routing)
//   rsp_*                     per-requester response beats (shared data/last)
//   err_o                     pulse on a completion with no burst outstanding
//   busy_o                    per-requester "burst in flight" flag
module cva6_refill_arbiter #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0][AddrWidth-1:0] req_addr_i,
  input  logic [1:0][7:0]           req_len_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [AddrWidth-1:0]      ar_addr_o,
  output logic [7:0]                ar_len_o,
  output logic [IdWidth-1:0]        ar_id_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [IdWidth-1:0]        r_id_i,
  input  logic                      r_last_i,
  input  logic [DataWidth-1:0]      r_data_i,
  output logic [1:0]                rsp_valid_o,
  input  logic [1:0]                rsp_ready_i,
  output logic [DataWidth-1:0]      rsp_data_o,
  output logic                      rsp_last_o,
  output logic                      err_o,
  output logic [1:0]                busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                   state_q, state_d;
  logic                     ptr_q, ptr_d;
  logic [AddrWidth-1:0]     ar_addr_q, ar_addr_d;
  logic [7:0]               ar_len_q, ar_len_d;
  logic [IdWidth-1:0]       ar_id_q, ar_id_d;
  logic [1:0][CntW-1:0]     cnt_q, cnt_d;

  logic [1:0] elig;
  logic       win;
  logic [1:0] inc;
  logic       r_tgt;
  logic       r_done;
  logic       r_id_unused;

  // Only bit 0 of the ID selects the requester.
  assign r_id_unused = ^r_id_i;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ar_id_d     = ar_id_q;
    req_ready_o = '0;
    inc         = '0;
    win         = 1'b0;
    elig        = req_valid_i & {(cnt_q[1] < CntMax), (cnt_q[0] < CntMax)};
    case (state_q)
      IDLE: begin
        if (elig != '0) begin
          // Pointer holder wins if eligible; a saturated one yields to the other.
          win              = elig[ptr_q] ? ptr_q : ~ptr_q;
          req_ready_o[win] = 1'b1;
          ar_addr_d        = req_addr_i[win];
          ar_len_d         = req_len_i[win];
          ar_id_d          = IdWidth'(win);
          ptr_d            = ~win;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_ready_i) begin
          inc[ar_id_q[0]] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_tgt              = r_id_i[0];
    rsp_valid_o        = '0;
    rsp_valid_o[r_tgt] = r_valid_i;
    r_ready_o          = rsp_ready_i[r_tgt];
    rsp_data_o         = r_data_i;
    rsp_last_o         = r_last_i;
    r_done             = r_valid_i & r_ready_o & r_last_i;
    err_o              = r_done && (cnt_q[r_tgt] == '0);
    cnt_d              = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      // Completion on an empty counter is reported via err_o, never underflows.
      cnt_d[i] = cnt_q[i] + CntW'(inc[i])
               - CntW'(r_done && (r_tgt == 1'(i)) && (cnt_q[i] != '0));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_id_q   <= ar_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ar_valid_o = (state_q == ISSUE);
  assign ar_addr_o  = ar_addr_q;
  assign ar_len_o   = ar_len_q;
  assign ar_id_o    = ar_id_q;
  assign busy_o     = {(cnt_q[1] != '0), (cnt_q[0] != '0)};

endmodule

// File: tb/tb_cva6_refill_arbiter.sv
module tb_cva6_refill_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int MAXO = 7;
  localparam logic [63:0] A0 = 64'h0000_0000_8000_0040;
  localparam logic [63:0] A1 = 64'h0000_0000_9000_0080;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][7:0]    req_len;
  logic               ar_valid, ar_ready;
  logic [AW-1:0]      ar_addr;
  logic [7:0]         ar_len;
  logic [IW-1:0]      ar_id;
  logic               r_valid, r_ready, r_last;
  logic [IW-1:0]      r_id;
  logic [DW-1:0]      r_data;
  logic [1:0]         rsp_valid, rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic               rsp_last, err;
  logic [1:0]         busy;

  int n_chk  = 0;
  int n_pass = 0;

  cva6_refill_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_id_o(ar_id),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_id_i(r_id),
    .r_last_i(r_last), .r_data_i(r_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: an optional pending AR descriptor, a rotating priority
  // owner and a per-requester count of bursts in flight.
  bit          m_pend;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  int          m_id;
  int          m_ptr;
  int          m_cnt[2];

  task automatic model_reset();
    m_pend = 0; m_addr = '0; m_len = '0; m_id = 0; m_ptr = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    req_valid = '0; ar_ready = 0; r_valid = 0; r_id = '0; r_last = 0;
    r_data = '0; rsp_ready = '0;
  endtask

  // Called just after a falling edge with inputs driven: compares every
  // output with the model, lets one rising edge pass, advances the model.
  task automatic step();
    int win;
    int t;
    bit done;
    bit dec;
    logic [1:0] e_rr;
    #1;
    e_rr = '0;
    win  = -1;
    if (!m_pend) begin
      for (int k = 0; k < 2; k++) begin
        int i;
        i = (k == 0) ? m_ptr : 1 - m_ptr;
        if (win < 0 && req_valid[i] && m_cnt[i] < MAXO) begin
          win = i;
          e_rr[i] = 1'b1;
        end
      end
    end
    check("req_ready", 64'(req_ready), 64'(e_rr));
    check("ar_valid", 64'(ar_valid), 64'(m_pend));
    if (m_pend) begin
      check("ar_addr", ar_addr, m_addr);
      check("ar_len", 64'(ar_len), 64'(m_len));
      check("ar_id", 64'(ar_id), 64'(m_id));
    end
    t = int'(r_id[0]);
    check("rsp_valid", 64'(rsp_valid), r_valid ? 64'(1 << t) : 64'd0);
    check("r_ready", 64'(r_ready), 64'(rsp_ready[t]));
    if (r_valid) begin
      check("rsp_data", rsp_data, r_data);
      check("rsp_last", 64'(rsp_last), 64'(r_last));
    end
    done = r_valid && rsp_ready[t] && r_last;
    check("err", 64'(err), 64'(done && m_cnt[t] == 0));
    check("busy", 64'(busy), 64'({m_cnt[1] != 0, m_cnt[0] != 0}));
    @(posedge clk);
    dec = done && m_cnt[t] > 0;
    if (win >= 0) begin
      m_pend = 1; m_addr = req_addr[win]; m_len = req_len[win];
      m_id = win; m_ptr = 1 - win;
    end else if (m_pend && ar_ready) begin
      m_cnt[m_id]++;
      m_pend = 0;
    end
    if (dec) m_cnt[t]--;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic        arr;
    logic        rvld;
    logic        rid;
    logic        rlast;
    logic [1:0]  rspr;
    logic [1:0]  e_rr;
    logic        e_arv;
    logic        e_id;
    logic [63:0] e_addr;
    logic [1:0]  e_rspv;
    logic        e_rready;
    logic        e_err;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t tv[13];

  initial begin
    tv[0]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 64'd0, 2'b00, 0, 0, 2'b00};
    tv[1]  = '{2'b01, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 64'd0, 2'b00, 0, 0, 2'b00};
    tv[2]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, A0,    2'b00, 0, 0, 2'b00};
    tv[3]  = '{2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, A0,    2'b00, 0, 0, 2'b00};
    tv[4]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 64'd0, 2'b00, 0, 0, 2'b01};
    tv[5]  = '{2'b00, 0, 1, 1, 1, 2'b10, 2'b00, 0, 0, 64'd0, 2'b10, 1, 1, 2'b01};
    tv[6]  = '{2'b00, 0, 1, 0, 1, 2'b11, 2'b00, 0, 0, 64'd0, 2'b01, 1, 0, 2'b01};
    tv[7]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 64'd0, 2'b00, 0, 0, 2'b00};
    tv[8]  = '{2'b11, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 64'd0, 2'b00, 0, 0, 2'b00};
    tv[9]  = '{2'b11, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, A1,    2'b00, 0, 0, 2'b00};
    tv[10] = '{2'b11, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 64'd0, 2'b00, 0, 0, 2'b10};
    tv[11] = '{2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, A0,    2'b00, 0, 0, 2'b10};
    tv[12] = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 64'd0, 2'b00, 0, 0, 2'b11};

    req_addr[0] = A0; req_len[0] = 8'd1;
    req_addr[1] = A1; req_len[1] = 8'd3;
    idle_inputs();
    rst = 1;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_ar_valid", 64'(ar_valid), 64'd0);
    check("rst_ar_addr", ar_addr, 64'd0);
    check("rst_ar_len", 64'(ar_len), 64'd0);
    check("rst_ar_id", 64'(ar_id), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 0;

    // Vector table: first transaction, R routing, empty-counter error, rotation
    for (int v = 0; v < 13; v++) begin
      req_valid = tv[v].rv; ar_ready = tv[v].arr; r_valid = tv[v].rvld;
      r_id = IW'(tv[v].rid); r_last = tv[v].rlast; rsp_ready = tv[v].rspr;
      r_data = tv[v].rid ? 64'hA : 64'hB;
      #1;
      check($sformatf("vec%0d_req_ready", v), 64'(req_ready), 64'(tv[v].e_rr));
      check($sformatf("vec%0d_ar_valid", v), 64'(ar_valid), 64'(tv[v].e_arv));
      if (tv[v].e_arv) begin
        check($sformatf("vec%0d_ar_id", v), 64'(ar_id), 64'(tv[v].e_id));
        check($sformatf("vec%0d_ar_addr", v), ar_addr, tv[v].e_addr);
      end
      check($sformatf("vec%0d_rsp_valid", v), 64'(rsp_valid), 64'(tv[v].e_rspv));
      check($sformatf("vec%0d_r_ready", v), 64'(r_ready), 64'(tv[v].e_rready));
      check($sformatf("vec%0d_err", v), 64'(err), 64'(tv[v].e_err));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'(tv[v].e_busy));
      step();
    end

    // Saturation: seven icache bursts, then icache blocked, dcache still served
    do_reset();
    req_valid = 2'b01; ar_ready = 1;
    repeat (2 * MAXO) step();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("sat_icache_blocked", 64'(req_ready), 64'd0);
      step();
    end
    req_valid = 2'b11;
    #1;
    check("sat_dcache_granted", 64'(req_ready), 64'b10);
    step();
    req_valid = 2'b00;
    step();
    r_valid = 1; r_id = '0; r_last = 1; rsp_ready = 2'b01; r_data = 64'h1234;
    step();
    r_valid = 0; r_last = 0; req_valid = 2'b01;
    #1;
    check("sat_icache_reaccepted", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b00;
    step();

    // AR stall: fields stable, no request acceptance while waiting
    do_reset();
    req_valid = 2'b10;
    step();
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_ar_valid", 64'(ar_valid), 64'd1);
      check("stall_ar_addr", ar_addr, A1);
      check("stall_ar_len", 64'(ar_len), 64'd3);
      check("stall_ar_id", 64'(ar_id), 64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    ar_ready = 1; req_valid = 2'b00;
    step();
    ar_ready = 0;
    step();

    // Reset asserted during ISSUE, then a stray beat after reset
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst = 1;
    model_reset();
    #1;
    check("midrst_ar_valid", 64'(ar_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 0;
    r_valid = 1; r_id = IW'(1); r_last = 1; rsp_ready = 2'b10; r_data = 64'h55;
    #1;
    check("post_rst_err", 64'(err), 64'd1);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'b10);
    step();
    idle_inputs();
    #1;
    check("post_rst_err_clear", 64'(err), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid   = 2'($urandom);
      req_addr[0] = {$urandom, $urandom};
      req_addr[1] = {$urandom, $urandom};
      req_len[0]  = 8'($urandom);
      req_len[1]  = 8'($urandom);
      ar_ready    = ($urandom_range(0, 2) != 0);
      r_valid     = ($urandom_range(0, 3) == 0);
      r_id        = IW'($urandom);
      r_last      = 1'($urandom);
      r_data      = {$urandom, $urandom};
      rsp_ready   = 2'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
